// File: rtl/ldm_scan_if.sv
// ----------------------------------------------------------------------------
// ldm_scan_if
//   Bundles the frame-load side (statistics path) and the LDM panel side of
//   the local-dimming scan controller.
//   Frame load : PIXEL_DATA, PIXEL_DATA_EN
//   Control    : SCAN_EN, BLANK
//   Panel      : LDM_CLK, LDM_ADDR_EN, LDM_ADDR, LDM_LINE_DATA
//   Status     : FRAME_DONE, OVERRUN
//   master = the side that loads frames and watches the panel pins,
//   slave  = the scan controller.
// ----------------------------------------------------------------------------
interface ldm_scan_if #(
   parameter int NUM_LINES = 16,
   parameter int LINE_W    = 16
);
   localparam int ADDR_W = $clog2(NUM_LINES);

   logic [NUM_LINES*LINE_W-1:0] PIXEL_DATA;
   logic                        PIXEL_DATA_EN;
   logic                        SCAN_EN;
   logic                        BLANK;
   logic                        LDM_CLK;
   logic                        LDM_ADDR_EN;
   logic [ADDR_W-1:0]           LDM_ADDR;
   logic [LINE_W-1:0]           LDM_LINE_DATA;
   logic                        FRAME_DONE;
   logic                        OVERRUN;

   modport master (
      output PIXEL_DATA, PIXEL_DATA_EN, SCAN_EN, BLANK,
      input  LDM_CLK, LDM_ADDR_EN, LDM_ADDR, LDM_LINE_DATA, FRAME_DONE, OVERRUN
   );

   modport slave (
      input  PIXEL_DATA, PIXEL_DATA_EN, SCAN_EN, BLANK,
      output LDM_CLK, LDM_ADDR_EN, LDM_ADDR, LDM_LINE_DATA, FRAME_DONE, OVERRUN
   );
endinterface

// File: rtl/ldm_scan_ctrl.sv
// ----------------------------------------------------------------------------
// ldm_scan_ctrl
//   Local-dimming scan controller. Captures a frame of zone data into a shadow
//   buffer, swaps it into the active buffer only between frames, and scans
//   NUM_LINES words of LINE_W bits to the panel, one per slot of 2*CLK_DIV
//   clk cycles. LDM_CLK rises mid-slot so address/data are stable around it.
//   Ports:
//     clk   system clock
//     rstn  asynchronous active-low reset
//     bus   ldm_scan_if slave: frame load, SCAN_EN/BLANK, panel pins, status
//   All panel/status outputs are registered.
// ----------------------------------------------------------------------------
module ldm_scan_ctrl #(
   parameter int NUM_LINES = 16,
   parameter int LINE_W    = 16,
   parameter int CLK_DIV   = 4
) (
   input  logic     clk,
   input  logic     rstn,
   ldm_scan_if.slave bus
);
   localparam int ADDR_W  = $clog2(NUM_LINES);
   localparam int FRAME_W = NUM_LINES * LINE_W;
   localparam int SLOT    = 2 * CLK_DIV;
   localparam int CNT_W   = $clog2(SLOT);

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SLOT - 1);
   localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(CLK_DIV);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_LINES - 1);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t              state, state_nx;
   logic [CNT_W-1:0]    cnt, cnt_nx;
   logic [ADDR_W-1:0]   addr, addr_nx;
   logic [FRAME_W-1:0]  shadow, active, active_nx;
   logic                pending, valid;
   logic                load, boundary, swap;

   logic                ldm_clk_nx, addr_en_nx, done_nx, overrun_nx;
   logic [ADDR_W-1:0]   ldm_addr_nx;
   logic [LINE_W-1:0]   data_nx;

   // NOTE: state register in its own always_ff with non-blocking assignment so
   // every flop samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nx;
   end

   // NOTE: every variable gets a default before the case so no path leaves a
   // value unassigned, which would otherwise infer a latch.
   always_comb begin
      load       = bus.PIXEL_DATA_EN;
      boundary   = (state == SCAN) && (cnt == CNT_LAST) && (addr == ADDR_LAST);
      // Swap only where it cannot tear a frame: anywhere while idle, or on the
      // very last cycle of a frame while scanning.
      swap       = pending && ((state == IDLE) || boundary);
      active_nx  = swap ? shadow : active;
      // A load racing a swap is not an overrun: the old shadow is consumed.
      overrun_nx = load && pending && !swap;
      done_nx    = boundary;

      state_nx    = state;
      cnt_nx      = '0;
      addr_nx     = '0;
      ldm_clk_nx  = 1'b0;
      addr_en_nx  = 1'b0;
      ldm_addr_nx = '0;
      data_nx     = '0;

      unique case (state)
         IDLE: begin
            if (bus.SCAN_EN && (valid || swap)) begin
               state_nx   = SCAN;
               addr_en_nx = 1'b1;
               data_nx    = bus.BLANK ? '0 : active_nx[LINE_W-1:0];
            end
         end
         SCAN: begin
            if (boundary && !bus.SCAN_EN) begin
               state_nx = IDLE;
            end else begin
               addr_en_nx = 1'b1;
               if (cnt == CNT_LAST) begin
                  addr_nx     = (addr == ADDR_LAST) ? '0 : addr + ADDR_W'(1);
                  ldm_addr_nx = addr_nx;
                  data_nx     = bus.BLANK ? '0
                                          : active_nx[int'(addr_nx) * LINE_W +: LINE_W];
               end else begin
                  // Mid-slot: hold address and data so they straddle the
                  // LDM_CLK rising edge.
                  cnt_nx      = cnt + CNT_W'(1);
                  addr_nx     = addr;
                  ldm_addr_nx = bus.LDM_ADDR;
                  data_nx     = bus.LDM_LINE_DATA;
               end
               ldm_clk_nx = (cnt_nx >= CNT_HALF);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: the frame buffers are plain flops, not RAM, so they are reset along
   // with everything else and a fresh scan can never show stale data.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt               <= '0;
         addr              <= '0;
         shadow            <= '0;
         active            <= '0;
         pending           <= 1'b0;
         valid             <= 1'b0;
         bus.LDM_CLK       <= 1'b0;
         bus.LDM_ADDR_EN   <= 1'b0;
         bus.LDM_ADDR      <= '0;
         bus.LDM_LINE_DATA <= '0;
         bus.FRAME_DONE    <= 1'b0;
         bus.OVERRUN       <= 1'b0;
      end else begin
         cnt    <= cnt_nx;
         addr   <= addr_nx;
         active <= active_nx;
         if (load) shadow <= bus.PIXEL_DATA;
         pending <= load || (pending && !swap);
         valid   <= valid || swap;
         bus.LDM_CLK       <= ldm_clk_nx;
         bus.LDM_ADDR_EN   <= addr_en_nx;
         bus.LDM_ADDR      <= ldm_addr_nx;
         bus.LDM_LINE_DATA <= data_nx;
         bus.FRAME_DONE    <= done_nx;
         bus.OVERRUN       <= overrun_nx;
      end
   end
endmodule
